// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding and PC defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  localparam int unsigned PC_W     = 10;
  localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC selection: stall/halt hold, absolute beats relative, else increment.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned D = PC_W
) (
  input  logic [D-1:0] prog_ctr,
  input  logic [D-1:0] target,
  input  logic         stall,
  input  logic         halt,
  input  logic         abs_jump,
  input  logic         rel_jump,
  output logic [D-1:0] pc_nxt,
  output logic         jump_conflict
);

  always_comb begin
    pc_nxt        = prog_ctr + D'(1);
    jump_conflict = 1'b0;
    if (stall || halt) begin
      pc_nxt = prog_ctr;
    end else if (abs_jump) begin
      pc_nxt        = target;
      jump_conflict = rel_jump;
    end else if (rel_jump) begin
      // D-bit add: carry drops out, so target acts as a two's-complement offset
      pc_nxt = prog_ctr + target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: architectural PC register, IDLE/RUN/HALTED handshake FSM and run-cycle counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned D  = PC_W,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          abs_jump,
  input  logic          rel_jump,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic          jump_err,
  output logic [CW-1:0] cycle_count
);

  state_t        state_q, state_d;
  logic [D-1:0]  pc_d, pc_nxt;
  logic [CW-1:0] cc_d;
  logic          err_d, jump_conflict;

  pc_next #(.D(D)) u_pc_next (
    .prog_ctr      (prog_ctr),
    .target        (target),
    .stall         (stall),
    .halt          (halt),
    .abs_jump      (abs_jump),
    .rel_jump      (rel_jump),
    .pc_nxt        (pc_nxt),
    .jump_conflict (jump_conflict)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = prog_ctr;
    cc_d    = cycle_count;
    err_d   = jump_err;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = D'(RESET_PC);
          cc_d    = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        pc_d = pc_nxt;
        if (!stall && halt) state_d = HALTED;
        if (cycle_count != '1) cc_d = cycle_count + CW'(1);
        if (jump_conflict) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prog_ctr    <= D'(RESET_PC);
      cycle_count <= '0;
      jump_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_ctr    <= pc_d;
      cycle_count <= cc_d;
      jump_err    <= err_d;
    end
  end

  // Status outputs are decoded from the state register, so they carry no input-to-output path.
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queued scoreboard of expected post-edge outputs.
module tb_fetch_ctrl;

  localparam int unsigned D  = 10;
  localparam int unsigned CW = 5;

  typedef struct {
    logic [D-1:0]  pc;
    logic          fv;
    logic          dn;
    logic          er;
    logic [CW-1:0] cc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, stall, halt, abs_jump, rel_jump;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid, done, jump_err;
  logic [CW-1:0] cycle_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fetch_ctrl #(.D(D), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .halt        (halt),
    .abs_jump    (abs_jump),
    .rel_jump    (rel_jump),
    .target      (target),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
    .done        (done),
    .jump_err    (jump_err),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      $error("%s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the edge, then compare.
  task automatic step(input logic r, s, sl, h, a, rl, input logic [D-1:0] t,
                      input logic [D-1:0] epc, input logic efv, edn, eer,
                      input logic [CW-1:0] ecc, input string tag);
    exp_t e;
    reset = r; start = s; stall = sl; halt = h; abs_jump = a; rel_jump = rl; target = t;
    sb.push_back('{pc: epc, fv: efv, dn: edn, er: eer, cc: ecc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, 32'(prog_ctr), 32'(e.pc));
    chk({tag, ".fv"}, 32'(fetch_valid), 32'(e.fv));
    chk({tag, ".done"}, 32'(done), 32'(e.dn));
    chk({tag, ".err"}, 32'(jump_err), 32'(e.er));
    chk({tag, ".cc"}, 32'(cycle_count), 32'(e.cc));
  endtask

  initial begin
    //    rst s sl h a r target    pc  fv dn er cc
    step(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 1, 1, 1, 10'h005, 10'h000, 0, 0, 0, 0, "idle_ignore");
    step(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, "start");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 0, 0, 0, 10'h000, D'(i), 1, 0, 0, CW'(i), "seq");
    step(0, 0, 0, 0, 1, 0, 10'h004, 10'h004, 1, 0, 0, 6, "abs4");
    step(0, 0, 0, 0, 0, 1, 10'h3FF, 10'h003, 1, 0, 0, 7, "rel_m1");
    step(0, 0, 0, 0, 1, 0, 10'h004, 10'h004, 1, 0, 0, 8, "abs4b");
    step(0, 0, 0, 0, 0, 1, 10'h3FB, 10'h3FF, 1, 0, 0, 9, "rel_m5");
    step(0, 0, 0, 0, 0, 1, 10'h014, 10'h013, 1, 0, 0, 10, "rel_wrap");
    step(0, 0, 0, 0, 1, 0, 10'h007, 10'h007, 1, 0, 0, 11, "abs7");
    step(0, 0, 0, 0, 1, 1, 10'd105, 10'd105, 1, 0, 1, 12, "conflict");
    step(0, 0, 0, 0, 0, 0, 10'h000, 10'd106, 1, 0, 1, 13, "err_sticky");
    step(0, 1, 0, 0, 0, 0, 10'h000, 10'd107, 1, 0, 1, 14, "start_midrun");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, 1, 0, 10'h000, 10'd107, 1, 0, 1, CW'(15 + i), "stall");
    step(0, 0, 0, 1, 0, 0, 10'h000, 10'd107, 0, 1, 1, 18, "halt");
    step(0, 0, 0, 0, 1, 1, 10'h055, 10'd107, 0, 1, 1, 18, "halted_hold");
    step(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, "restart");
    step(0, 0, 0, 0, 1, 0, 10'h3FE, 10'h3FE, 1, 0, 0, 1, "abs3fe");
    step(0, 0, 0, 0, 0, 0, 10'h000, 10'h3FF, 1, 0, 0, 2, "inc3ff");
    step(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 3, "inc_wrap");
    step(0, 0, 0, 0, 1, 0, 10'd50, 10'd50, 1, 0, 0, 4, "abs50");
    step(1, 0, 0, 1, 1, 0, 10'h009, 10'h000, 0, 0, 0, 0, "reset_midrun");
    step(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, "idle_after_reset");
    step(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, "start_sat");
    for (int i = 1; i <= 34; i++)
      step(0, 0, 0, 0, 0, 0, 10'h000, D'(i), 1, 0, 0, (i > 31) ? CW'(31) : CW'(i), "saturate");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
